// File: rtl/dcache_write_buffer.sv
// Posted write buffer between the data cache and slow memory: absorbs line writebacks
// in a small FIFO, forwards buffered lines to read misses, and drains when idle or full.
module dcache_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic                     clk,
    input  logic                     proc_reset,
    input  logic                     c_read,
    input  logic                     c_write,
    input  logic [ADDR_W-1:0]        c_addr,
    input  logic [DATA_W-1:0]        c_wdata,
    output logic [DATA_W-1:0]        c_rdata,
    output logic                     c_ready,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata,
    input  logic                     mem_ready,
    output logic [$clog2(DEPTH):0]   wb_count,
    output logic                     wb_empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_RESP} state_e;

    state_e                          state_q, state_d;
    logic [PTR_W-1:0]                head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]                count_q, count_d;
    logic [DEPTH-1:0]                valid_q, valid_d;
    logic [DEPTH-1:0][ADDR_W-1:0]    addr_q, addr_d;
    logic [DEPTH-1:0][DATA_W-1:0]    data_q, data_d;
    logic [DATA_W-1:0]               c_rdata_q, c_rdata_d;
    logic                            c_ready_q, c_ready_d;
    logic                            mem_read_q, mem_read_d;
    logic                            mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]               mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]               mem_wdata_q, mem_wdata_d;

    logic                            hit;
    logic [PTR_W-1:0]                hit_idx;
    logic                            full;
    logic                            drain_go;

    // Coalescing guarantees at most one valid entry matches, so the last match wins trivially.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && addr_q[i] == c_addr) begin
                hit     = 1'b1;
                hit_idx = PTR_W'(i);
            end
        end
    end

    assign full = (count_q == CNT_W'(DEPTH));

    always_comb begin
        state_d     = state_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        valid_d     = valid_q;
        addr_d      = addr_q;
        data_d      = data_q;
        c_rdata_d   = c_rdata_q;
        c_ready_d   = 1'b0;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        drain_go    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (c_read) begin
                    if (hit) begin
                        c_rdata_d = data_q[hit_idx];
                        c_ready_d = 1'b1;
                        state_d   = S_RESP;
                    end else begin
                        mem_read_d = 1'b1;
                        mem_addr_d = c_addr;
                        state_d    = S_READ;
                    end
                end else if (c_write) begin
                    if (hit) begin
                        data_d[hit_idx] = c_wdata;
                        c_ready_d       = 1'b1;
                        state_d         = S_RESP;
                    end else if (!full) begin
                        valid_d[tail_q] = 1'b1;
                        addr_d[tail_q]  = c_addr;
                        data_d[tail_q]  = c_wdata;
                        tail_d          = tail_q + PTR_W'(1);
                        count_d         = count_q + CNT_W'(1);
                        c_ready_d       = 1'b1;
                        state_d         = S_RESP;
                    end else begin
                        // Full with no match: free a slot; the write is retried from IDLE.
                        drain_go = 1'b1;
                    end
                end else if (count_q != '0) begin
                    drain_go = 1'b1;
                end
            end
            S_READ: begin
                if (mem_ready) begin
                    c_rdata_d  = mem_rdata;
                    mem_read_d = 1'b0;
                    c_ready_d  = 1'b1;
                    state_d    = S_RESP;
                end
            end
            S_DRAIN: begin
                if (mem_ready) begin
                    valid_d[head_q] = 1'b0;
                    head_d          = head_q + PTR_W'(1);
                    count_d         = count_q - CNT_W'(1);
                    mem_write_d     = 1'b0;
                    state_d         = S_IDLE;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (drain_go) begin
            mem_write_d = 1'b1;
            mem_addr_d  = addr_q[head_q];
            mem_wdata_d = data_q[head_q];
            state_d     = S_DRAIN;
        end
    end

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state_q     <= S_IDLE;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            valid_q     <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            c_rdata_q   <= '0;
            c_ready_q   <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            valid_q     <= valid_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            c_rdata_q   <= c_rdata_d;
            c_ready_q   <= c_ready_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign c_rdata   = c_rdata_q;
    assign c_ready   = c_ready_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign wb_count  = count_q;
    assign wb_empty  = (count_q == '0);

endmodule

// File: tb/tb_dcache_write_buffer.sv
// Directed bench for dcache_write_buffer: writes, full-buffer drain, read hit/miss,
// coalescing on a full buffer, and reset in the middle of a drain.
module tb_dcache_write_buffer;
    localparam int AW = 28;
    localparam int DW = 128;
    localparam int CW = 3;

    localparam logic [DW-1:0] DA  = {4{32'hAAAA_0010}};
    localparam logic [DW-1:0] D1  = {4{32'h1111_0001}};
    localparam logic [DW-1:0] DB  = {4{32'hBBBB_0002}};
    localparam logic [DW-1:0] DC  = {4{32'hCCCC_0003}};
    localparam logic [DW-1:0] D4  = {4{32'h4444_0004}};
    localparam logic [DW-1:0] D5  = {4{32'h5555_0005}};
    localparam logic [DW-1:0] DC2 = {4{32'hC2C2_0033}};
    localparam logic [DW-1:0] DR  = {4{32'h7E7E_0007}};
    localparam logic [DW-1:0] DF  = {4{32'hF0F0_0009}};

    logic          clk = 1'b0;
    logic          proc_reset = 1'b1;
    logic          c_read = 1'b0, c_write = 1'b0;
    logic [AW-1:0] c_addr = '0;
    logic [DW-1:0] c_wdata = '0, mem_rdata = '0;
    logic          mem_ready = 1'b0;
    logic [DW-1:0] c_rdata, mem_wdata;
    logic          c_ready, mem_read, mem_write, wb_empty;
    logic [AW-1:0] mem_addr;
    logic [CW-1:0] wb_count;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    dcache_write_buffer #(.DEPTH(4), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .proc_reset(proc_reset),
        .c_read(c_read), .c_write(c_write), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_rdata(c_rdata), .c_ready(c_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .wb_count(wb_count), .wb_empty(wb_empty)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives a request at a negedge and holds it until c_ready is seen; lat counts
    // negedges from drive to c_ready; saw_mem flags any memory request meanwhile.
    task automatic cache_req(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             output int lat, output bit saw_mem);
        c_read = !wr; c_write = wr; c_addr = a; c_wdata = d;
        lat = 0; saw_mem = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (mem_read || mem_write) saw_mem = 1'b1;
        end while (!c_ready && lat < 30);
        c_read = 1'b0; c_write = 1'b0;
    endtask

    task automatic drain_one(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [CW-1:0] cnt_after);
        int n = 0;
        while (!mem_write && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_mem_write"}, DW'(mem_write), DW'(1));
        chk({tag, "_mem_read_off"}, DW'(mem_read), DW'(0));
        chk({tag, "_addr"}, DW'(mem_addr), DW'(a));
        chk({tag, "_wdata"}, mem_wdata, d);
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        chk({tag, "_write_drop"}, DW'(mem_write), DW'(0));
        chk({tag, "_count"}, DW'(wb_count), DW'(cnt_after));
    endtask

    initial begin
        int lat;
        bit saw;
        int n;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_c_ready", DW'(c_ready), DW'(0));
        chk("rst_mem_read", DW'(mem_read), DW'(0));
        chk("rst_mem_write", DW'(mem_write), DW'(0));
        chk("rst_c_rdata", c_rdata, '0);
        chk("rst_count", DW'(wb_count), DW'(0));
        chk("rst_empty", DW'(wb_empty), DW'(1));
        proc_reset = 1'b0;
        @(negedge clk);

        // Single write from an idle, empty buffer, then it drains
        cache_req(1'b1, 28'h0000010, DA, lat, saw);
        chk("w1_lat", DW'(lat), DW'(1));
        chk("w1_count", DW'(wb_count), DW'(1));
        drain_one("w1_drain", 28'h0000010, DA, 3'd0);
        chk("w1_empty", DW'(wb_empty), DW'(1));

        // Back-to-back writes fill the buffer while memory is stalled (wraps the pointers)
        cache_req(1'b1, 28'h1, D1, lat, saw);
        chk("f1_lat", DW'(lat), DW'(1));
        cache_req(1'b1, 28'h2, DB, lat, saw);
        chk("f2_lat", DW'(lat), DW'(2));
        cache_req(1'b1, 28'h3, DC, lat, saw);
        chk("f3_lat", DW'(lat), DW'(2));
        cache_req(1'b1, 28'h4, D4, lat, saw);
        chk("f4_lat", DW'(lat), DW'(2));
        chk("f4_count", DW'(wb_count), DW'(4));
        chk("f4_nomem", DW'(saw), DW'(0));

        // Fifth write: full, no match -> oldest entry drains first
        c_write = 1'b1; c_addr = 28'h5; c_wdata = D5;
        repeat (2) @(negedge clk);
        chk("f5_drain_write", DW'(mem_write), DW'(1));
        chk("f5_drain_addr", DW'(mem_addr), DW'(28'h1));
        chk("f5_drain_data", mem_wdata, D1);
        repeat (3) @(negedge clk);
        chk("f5_stall_no_ready", DW'(c_ready), DW'(0));
        chk("f5_stall_addr", DW'(mem_addr), DW'(28'h1));
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        chk("f5_pop_write", DW'(mem_write), DW'(0));
        chk("f5_pop_count", DW'(wb_count), DW'(3));
        chk("f5_pop_no_ready", DW'(c_ready), DW'(0));
        @(negedge clk);
        chk("f5_ready", DW'(c_ready), DW'(1));
        chk("f5_count", DW'(wb_count), DW'(4));

        // Read hit on buffered 0x2
        cache_req(1'b0, 28'h2, '0, lat, saw);
        chk("hit_lat", DW'(lat), DW'(2));
        chk("hit_data", c_rdata, DB);
        chk("hit_nomem", DW'(saw), DW'(0));

        // Read miss on 0x7 with a 10-cycle memory
        c_read = 1'b1; c_addr = 28'h7;
        n = 0;
        while (!mem_read && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("miss_start", DW'(n), DW'(2));
        chk("miss_addr", DW'(mem_addr), DW'(28'h7));
        n = 1;
        repeat (9) begin
            @(negedge clk);
            if (mem_read && !mem_write && mem_addr == 28'h7 && !c_ready) n++;
        end
        chk("miss_held", DW'(n), DW'(10));
        mem_ready = 1'b1; mem_rdata = DR;
        @(negedge clk);
        mem_ready = 1'b0; mem_rdata = '0;
        chk("miss_ready", DW'(c_ready), DW'(1));
        chk("miss_data", c_rdata, DR);
        chk("miss_read_drop", DW'(mem_read), DW'(0));
        chk("miss_count", DW'(wb_count), DW'(4));

        // Coalesce into 0x3 while full: no drain
        cache_req(1'b1, 28'h3, DC2, lat, saw);
        chk("coal_lat", DW'(lat), DW'(2));
        chk("coal_nomem", DW'(saw), DW'(0));
        chk("coal_count", DW'(wb_count), DW'(4));

        // Drain order shows final contents 0x2..0x5 with the coalesced data
        drain_one("d2", 28'h2, DB, 3'd3);
        drain_one("d3", 28'h3, DC2, 3'd2);
        drain_one("d4", 28'h4, D4, 3'd1);
        drain_one("d5", 28'h5, D5, 3'd0);
        chk("d_empty", DW'(wb_empty), DW'(1));

        // Reset in the middle of a drain
        cache_req(1'b1, 28'h9, DF, lat, saw);
        chk("r_lat", DW'(lat), DW'(1));
        n = 0;
        while (!mem_write && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("r_draining", DW'(mem_write), DW'(1));
        proc_reset = 1'b1;
        @(negedge clk);
        chk("r_mem_write", DW'(mem_write), DW'(0));
        chk("r_count", DW'(wb_count), DW'(0));
        chk("r_c_ready", DW'(c_ready), DW'(0));
        chk("r_empty", DW'(wb_empty), DW'(1));
        proc_reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("r_idle_no_drain", DW'(mem_write), DW'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
